// File: rtl/aed_shock_controller.sv
// AED control FSM: qualified analysis window, capacitor charge, bounded multi-shock sequence.
// Optional ARMED dwell timeout enabled by defining AED_ARM_TIMEOUT_EN.
module aed_shock_controller #(
   parameter int ANALYSIS_CYCLES    = 4,
   parameter int CHARGE_CYCLES      = 8,
   parameter int MAX_SHOCKS         = 3,
   parameter int COOLDOWN_CYCLES    = 5,
   parameter int ARM_TIMEOUT_CYCLES = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              hb,
   input  logic                              reg_hb,
   input  logic                              btn,
   output logic                              light,
   output logic                              charging,
   output logic                              shock,
   output logic                              lockout,
   output logic [$clog2(MAX_SHOCKS+1)-1:0]   shock_count,
   output logic [2:0]                        state_o
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAXP = max2(max2(ANALYSIS_CYCLES, CHARGE_CYCLES),
                              max2(COOLDOWN_CYCLES, ARM_TIMEOUT_CYCLES));
   localparam int TW   = $clog2(MAXP) + 1;
   localparam int CW   = $clog2(MAX_SHOCKS + 1);

   typedef enum logic [2:0] {
      WAIT     = 3'd0,
      MEASURE  = 3'd1,
      ANALYZE  = 3'd2,
      CHARGE   = 3'd3,
      ARMED    = 3'd4,
      SHOCK    = 3'd5,
      COOLDOWN = 3'd6,
      LOCKOUT  = 3'd7
   } state_t;

   state_t          state, state_nxt;
   logic [TW-1:0]   timer;
   logic            timer_run;
   logic            last_shock;

   assign last_shock = (shock_count >= CW'(MAX_SHOCKS - 1));

   always_comb begin
      timer_run = 1'b0;
      case (state)
         ANALYZE, CHARGE, COOLDOWN: timer_run = 1'b1;
`ifdef AED_ARM_TIMEOUT_EN
         ARMED:                     timer_run = 1'b1;
`endif
         default:                   timer_run = 1'b0;
      endcase
   end

   // State register, phase timer and shock counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= WAIT;
         timer       <= '0;
         shock_count <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            timer <= '0;
         else if (timer_run)
            timer <= timer + TW'(1);
         if (state == SHOCK && shock_count != CW'(MAX_SHOCKS))
            shock_count <= shock_count + CW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT: begin
            if (hb) state_nxt = MEASURE;
         end
         MEASURE: begin
            if (!hb)         state_nxt = WAIT;
            else if (!reg_hb) state_nxt = ANALYZE;
         end
         ANALYZE: begin
            if (!hb)                                   state_nxt = WAIT;
            else if (reg_hb)                           state_nxt = MEASURE;
            else if (timer == TW'(ANALYSIS_CYCLES - 1)) state_nxt = CHARGE;
         end
         CHARGE: begin
            if (!hb)                                 state_nxt = WAIT;
            else if (reg_hb)                         state_nxt = MEASURE;
            else if (timer == TW'(CHARGE_CYCLES - 1)) state_nxt = ARMED;
         end
         ARMED: begin
            if (!hb)         state_nxt = WAIT;
            else if (reg_hb) state_nxt = MEASURE;
            else if (btn)    state_nxt = SHOCK;
`ifdef AED_ARM_TIMEOUT_EN
            else if (timer == TW'(ARM_TIMEOUT_CYCLES - 1)) state_nxt = WAIT;
`endif
         end
         SHOCK: begin
            state_nxt = last_shock ? LOCKOUT : COOLDOWN;
         end
         COOLDOWN: begin
            if (timer == TW'(COOLDOWN_CYCLES - 1)) state_nxt = MEASURE;
         end
         LOCKOUT: begin
            state_nxt = LOCKOUT;
         end
         default: state_nxt = WAIT;
      endcase
   end

   always_comb begin
      light    = 1'b0;
      charging = 1'b0;
      shock    = 1'b0;
      lockout  = 1'b0;
      case (state)
         ARMED:   light    = 1'b1;
         CHARGE:  charging = 1'b1;
         SHOCK:   shock    = 1'b1;
         LOCKOUT: lockout  = 1'b1;
         default: ;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_aed_shock_controller.sv
// Directed vector bench for aed_shock_controller with default parameters.
module tb_aed_shock_controller;

   localparam logic [2:0] S_W = 3'd0, S_M = 3'd1, S_A = 3'd2, S_C = 3'd3,
                          S_R = 3'd4, S_S = 3'd5, S_D = 3'd6, S_L = 3'd7;

   logic       clk = 1'b0;
   logic       reset, hb, reg_hb, btn;
   logic       light, charging, shock, lockout;
   logic [1:0] shock_count;
   logic [2:0] state_o;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       hb;
      logic       rg;
      logic       btn;
      logic [2:0] st;
      logic [1:0] cnt;
   } vec_t;

   vec_t tbl[$];

   aed_shock_controller dut (
      .clk         (clk),
      .reset       (reset),
      .hb          (hb),
      .reg_hb      (reg_hb),
      .btn         (btn),
      .light       (light),
      .charging    (charging),
      .shock       (shock),
      .lockout     (lockout),
      .shock_count (shock_count),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input int idx, input logic [2:0] st, input logic [1:0] cnt);
      chk({name, ".state"},    idx, 32'(state_o),     32'(st));
      chk({name, ".light"},    idx, 32'(light),       32'(st == S_R));
      chk({name, ".charging"}, idx, 32'(charging),    32'(st == S_C));
      chk({name, ".shock"},    idx, 32'(shock),       32'(st == S_S));
      chk({name, ".lockout"},  idx, 32'(lockout),     32'(st == S_L));
      chk({name, ".count"},    idx, 32'(shock_count), 32'(cnt));
   endtask

   task automatic run(input logic h, input logic r, input logic b,
                      input logic [2:0] s, input logic [1:0] c, input int n);
      vec_t v;
      v.hb = h; v.rg = r; v.btn = b; v.st = s; v.cnt = c;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   initial begin
      // Vector table: inputs applied before an edge, state/count expected after it.
      run(0,0,0, S_W,0, 2);
      run(1,1,0, S_M,0, 1);
      run(1,1,0, S_M,0, 2);
      run(0,0,0, S_W,0, 1);
      run(1,0,0, S_M,0, 1);
      run(1,0,0, S_A,0, 3);
      run(1,1,0, S_M,0, 1);   // regular beat in ANALYZE cycle 3 aborts
      run(1,0,0, S_A,0, 4);
      run(1,0,0, S_C,0, 8);
      run(1,0,0, S_R,0, 1);
`ifdef AED_ARM_TIMEOUT_EN
      run(1,0,0, S_R,0, 15);
      run(1,0,0, S_W,0, 1);
      run(1,0,0, S_M,0, 1);
      run(1,0,0, S_A,0, 4);
      run(1,0,0, S_C,0, 8);
      run(1,0,0, S_R,0, 1);
`else
      run(1,0,0, S_R,0, 100);
`endif
      run(1,0,1, S_S,0, 1);   // first shock
      run(0,1,1, S_D,1, 5);   // inputs ignored during cooldown
      run(0,1,1, S_M,1, 1);
      run(1,0,1, S_A,1, 4);
      run(1,0,1, S_C,1, 3);
      run(0,0,1, S_W,1, 1);   // hb loss dumps charge
      run(1,0,1, S_M,1, 1);
      run(1,0,1, S_A,1, 4);
      run(1,0,1, S_C,1, 8);
      run(1,0,1, S_R,1, 1);
      run(1,1,1, S_M,1, 1);   // reg_hb beats btn in ARMED
      run(1,0,1, S_A,1, 4);
      run(1,0,1, S_C,1, 8);
      run(1,0,1, S_R,1, 1);
      run(1,0,1, S_S,1, 1);   // btn held on ARMED entry
      run(1,0,1, S_D,2, 5);
      run(1,0,1, S_M,2, 1);
      run(1,0,1, S_A,2, 4);
      run(1,0,1, S_C,2, 2);
      run(1,1,1, S_M,2, 1);   // reg_hb in CHARGE dumps
      run(1,0,1, S_A,2, 4);
      run(1,0,1, S_C,2, 8);
      run(1,0,1, S_R,2, 1);
      run(1,0,1, S_S,2, 1);
      run(1,0,1, S_L,3, 5);
      run(0,0,0, S_L,3, 2);
      run(1,1,1, S_L,3, 2);

      reset = 1'b1; hb = 1'b0; reg_hb = 1'b0; btn = 1'b0;
      @(posedge clk); #1;
      chk_all("reset", 0, S_W, 0);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         hb = tbl[i].hb; reg_hb = tbl[i].rg; btn = tbl[i].btn;
         @(posedge clk); #1;
         chk_all("vec", i, tbl[i].st, tbl[i].cnt);
      end

      // Reset out of LOCKOUT clears the count
      reset = 1'b1; #1;
      chk_all("rst_lock", 0, S_W, 0);
      reset = 1'b0;

      // Async reset in the middle of CHARGE
      hb = 1'b1; reg_hb = 1'b0; btn = 1'b0;
      repeat (1 + 4 + 3) @(posedge clk);
      #1;
      chk("midchg.charging_pre", 0, 32'(charging), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midchg.state", 0, 32'(state_o), 32'd0);
      chk("midchg.charging", 0, 32'(charging), 32'd0);
      reset = 1'b0;

      // Async reset during the shock pulse
      repeat (1 + 4 + 8 + 1) @(posedge clk);
      #1;
      chk("preshock.light", 0, 32'(light), 32'd1);
      btn = 1'b1;
      @(posedge clk); #1;
      chk("shockrst.shock_pre", 0, 32'(shock), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("shockrst.shock", 0, 32'(shock), 32'd0);
      chk("shockrst.state", 0, 32'(state_o), 32'd0);
      chk("shockrst.count", 0, 32'(shock_count), 32'd0);
      @(posedge clk); #1;
      chk("shockrst.count_hold", 0, 32'(shock_count), 32'd0);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
